// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the multi-channel clock divider.
//   cnt_t      : counter/config word at the default width (16 bits)
//   ch_idx_t   : channel index wide enough for the 16-channel maximum
//   chan_cfg_t : {div, high} pair, the unit of one configuration write
//   CFG_DIV_MIN: smallest divisor a channel will run with; smaller writes clamp up
package clk_div_pkg;
  localparam int CW_DEF      = 16;
  localparam int CFG_DIV_MIN = 2;

  typedef logic [CW_DEF-1:0] cnt_t;
  typedef logic [3:0]        ch_idx_t;

  typedef struct packed {
    cnt_t div;
    cnt_t high;
  } chan_cfg_t;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
//   Period counter, active config, one-deep shadow config, registered clk_out/tick.
//   Optional SYNC_RESTART_EN macro adds the `sync` input (restart period when enabled).
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   en              run enable
//   sync            [SYNC_RESTART_EN] force period restart this edge
//   wr              accepted config write for this channel (only while !pend_vld)
//   wr_div, wr_high raw config values; divisor clamped here
//   pend_vld        shadow config waiting for a period boundary
//   clk_out, tick   registered divided clock and period-start pulse
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW       = 16,
  parameter int DEF_DIV  = 5000,
  parameter int DEF_HIGH = 2500
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef SYNC_RESTART_EN
  input  logic          sync,
`endif
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  input  logic [CW-1:0] wr_high,
  output logic          pend_vld,
  output logic          clk_out,
  output logic          tick
);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DIV_MIN = CW'(CFG_DIV_MIN);

  logic [CW-1:0] cnt, act_div, act_high, pend_div, pend_high;
  logic [CW-1:0] cnt_nxt, nxt_div, nxt_high;
  logic          restart, wrap, apply;

`ifdef SYNC_RESTART_EN
  assign restart = sync;
`else
  assign restart = 1'b0;
`endif

  // Wrap is judged against the old divisor; a shadow config swapped in on the
  // same edge governs the period that is just starting.
  assign wrap     = en && ((cnt == act_div - ONE) || restart);
  assign apply    = pend_vld && (!en || wrap);
  assign cnt_nxt  = wrap ? '0 : cnt + ONE;
  assign nxt_div  = apply ? pend_div  : act_div;
  assign nxt_high = apply ? pend_high : act_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= CW'(DEF_DIV - 1);
      act_div   <= CW'(DEF_DIV);
      act_high  <= CW'(DEF_HIGH);
      pend_div  <= '0;
      pend_high <= '0;
      pend_vld  <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      act_div  <= nxt_div;
      act_high <= nxt_high;
      // wr only arrives while pend_vld is low, so it never races apply.
      if (wr) begin
        pend_div  <= (wr_div < DIV_MIN) ? DIV_MIN : wr_div;
        pend_high <= wr_high;
        pend_vld  <= 1'b1;
      end else if (apply) begin
        pend_vld  <= 1'b0;
      end
      if (en) begin
        cnt     <= cnt_nxt;
        clk_out <= (cnt_nxt < nxt_high);
        tick    <= (cnt_nxt == '0);
      end else begin
        // Park one short of wrap so enabling restarts the period on the next edge.
        cnt     <= nxt_div - ONE;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH-channel programmable clock divider.
//   Each channel has a runtime divisor/high-time, a registered clk_out and a
//   one-cycle tick at period start. Config writes are shadowed and take effect
//   at that channel's next period boundary (or immediately if disabled).
//   Optional macro SYNC_RESTART_EN adds a `sync` input that restarts the period
//   on all enabled channels.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   en[NCH]             per-channel run enable
//   sync                [SYNC_RESTART_EN] global period restart
//   cfg_valid/cfg_ready config write handshake; ready = target has no pending write
//   cfg_ch              target channel; out-of-range index accepted and dropped
//   cfg_div, cfg_high   period and high-time in cycles
//   clk_out[NCH]        divided clocks
//   tick[NCH]           period-start pulses
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int CW       = 16,
  parameter  int DEF_DIV  = 5000,
  parameter  int DEF_HIGH = 2500,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
`ifdef SYNC_RESTART_EN
  input  logic           sync,
`endif
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [CW-1:0]  cfg_high,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);
  logic [NCH-1:0]      pend_vld;
  logic [2**CHW-1:0]   pend_pad;
  logic                accept;

  // Unused index slots read as "not pending" so stray writes are swallowed.
  always_comb begin
    pend_pad           = '0;
    pend_pad[NCH-1:0]  = pend_vld;
  end

  assign cfg_ready = !pend_pad[cfg_ch];
  assign accept    = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(
      .CW       (CW),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[g]),
`ifdef SYNC_RESTART_EN
      .sync     (sync),
`endif
      .wr       (accept && (cfg_ch == CHW'(g))),
      .wr_div   (cfg_div),
      .wr_high  (cfg_high),
      .pend_vld (pend_vld[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end
endmodule
